mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one output channel between four requesters by sequencing the select of the 4:1 mux datapath. Each requester presents req plus data. The arbiter grants one requester at a time, holds the grant for a bounded burst, then rotates priority. It drives sel and one-hot gnt for the mux, and a valid/ready handshake on the shared output.

Parameters:
DATA_W, 1, width of each requester's data and of out_data
MAX_BURST, 4, maximum beats accepted per grant before forced release (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  4  request per requester; bit i high = requester i has a beat available
in_data  input  4*DATA_W  packed requester data; slice i belongs to requester i
in_ready  output  4  in_ready[i] = gnt[i] & out_ready; requester i's beat is consumed when req[i] & in_ready[i]
out_valid  output  1  shared channel valid
out_ready  input  1  shared channel ready from downstream
out_data  output  DATA_W  data of the granted requester
sel  output  2  registered mux select, index of current/last grant
gnt  output  4  registered one-hot grant, all-zero when idle

Behaviour:
- Reset (rst high at an edge): state=IDLE, gnt=0000, sel=00, ptr=0, beat_cnt=0. out_valid=0 and in_ready=0000 in the cycle after reset is sampled. Reset wins over every other event.
- States: IDLE, BUSY. ptr (2 bits) is the highest-priority index for the next arbitration.
- IDLE: gnt=0 and out_valid=0.
  - If req != 0 at an edge, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Next cycle: sel=winner, gnt=onehot(winner), beat_cnt=0, state=BUSY.
  - Latency from req sampled to gnt asserted is 1 cycle.
- BUSY:
  - out_valid = req[sel] (combinational).
  - out_data = in_data slice sel (combinational, via the mux).
  - A beat is accepted when out_valid & out_ready at an edge. On an accepted beat, beat_cnt increments.
- Release conditions, evaluated at each edge in BUSY:
  - (a) req[sel]=0, or
  - (b) an accepted beat with beat_cnt == MAX_BURST-1.
  - On release: gnt=0000, ptr=(sel+1) mod 4, beat_cnt=0, state=IDLE. sel keeps its last value.
  - Exactly one idle bubble cycle separates consecutive grants.
- Backpressure: while out_ready=0 and req[sel]=1, the grant is held indefinitely with no timeout, and beat_cnt holds.
- A requester that drops req while not granted simply loses its pending request. No state is kept per requester.
- Simultaneous events:
  - Release and a new req on the same edge: the new req is evaluated in the following IDLE cycle.
  - req[sel] drops on the same edge as a would-be beat: no beat is accepted (out_valid was 0).
- MAX_BURST=1: release after every accepted beat.
- beat_cnt width is max(1, clog2(MAX_BURST)). The counter never exceeds MAX_BURST-1.
- Reset mid-burst: any beat not yet accepted is dropped, and ptr returns to 0.
- gnt is always one-hot or zero. sel always equals the index of gnt when gnt != 0.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2
  - state enum {IDLE, BUSY}
  - function onehot4(idx)
- Sub-module rr_pick4: combinational rotate-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
- Data path: DATA_W instances of the existing mux_4to1, one per bit, with sel driven from the registered sel.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, out_valid=0, in_ready=0000 while rst is high and for 1 cycle after.
- Single requester: req=0100, in_data[2]=1, out_ready=1 -> gnt=0100 and sel=10 one cycle later. 4 beats with out_data=1. Then gnt=0000 for 1 cycle and ptr=3. gnt=0100 is re-granted on the next cycle.
- Full contention: req=1111 held, out_ready=1, MAX_BURST=4 -> grant order 0,1,2,3,0. Each grant carries exactly 4 beats with 1 bubble between grants. Throughput is 4 beats per 5 cycles.
- Backpressure: req[1] granted, out_ready=0 for 10 cycles -> gnt=0010 stable, in_ready=0000, beat_cnt unchanged. out_ready=1 resumes beats.
- Early release: req=1000 then req=1001. req[3] drops after 2 accepted beats -> IDLE for 1 cycle, then gnt=0001 (ptr=0), sel=00.
- Reset mid-burst: rst=1 after 2 beats of requester 2 -> next cycle gnt=0000, out_valid=0. After rst=0 with req=0110, the winner is requester 1 (ptr=0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_4to1.sv
// Single-bit 4:1 multiplexer used as the per-bit data path slice.
module mux_4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a 4:1 data mux, with bounded bursts per grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          sel,
  output logic [NUM_REQ-1:0]        gnt
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             accept;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    out_valid  = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = BUSY;
          sel_d      = pick_idx;
          gnt_d      = onehot4(pick_idx);
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        out_valid = req[sel_q];
        accept    = out_valid & out_ready;
        // Release on a dropped request or on the last beat of a burst.
        if (!req[sel_q] || (accept && beat_cnt_q == LastBeat)) begin
          state_d    = IDLE;
          gnt_d      = '0;
          ptr_d      = sel_q + 1'b1;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign in_ready = gnt_q & {NUM_REQ{out_ready}};
  assign sel      = sel_q;
  assign gnt      = gnt_q;

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    mux_4to1 u_mux (
      .d ({in_data[3*DATA_W+b], in_data[2*DATA_W+b], in_data[DATA_W+b], in_data[b]}),
      .s (sel_q),
      .y (out_data[b])
    );
  end

endmodule
